// File: rtl/ram_multi_read_port.sv
// Register-file RAM: one write port, NUM_READ registered read ports, range checks and a zero sweep.
// Define RAM_WRITE_FORWARD_EN for write-first same-address reads; the default build is read-first.
module ram_multi_read_port #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_SIZE   = 8,
    parameter int NUM_READ   = 2
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           iClear,
    input  logic                           iWriteEnable,
    input  logic [ADDR_WIDTH-1:0]          iWriteAddress,
    input  logic [DATA_WIDTH-1:0]          iDataIn,
    input  logic [NUM_READ-1:0]            iReadEnable,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] iReadAddress,
    output logic [NUM_READ*DATA_WIDTH-1:0] oDataOut,
    output logic [NUM_READ-1:0]            oDataValid,
    output logic [NUM_READ-1:0]            oAddrError,
    output logic                           oWriteError,
    output logic                           oBusy
);

    localparam int                  IDX_W    = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [ADDR_WIDTH:0] LP_LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE);
    localparam logic [IDX_W-1:0]    LP_LAST  = IDX_W'(MEM_SIZE-1);
    localparam logic [0:0]          ST_CLEAR = 1'b0;
    localparam logic [0:0]          ST_RUN   = 1'b1;

    logic [0:0]                     r_state;
    logic [IDX_W-1:0]               r_count;
    logic [DATA_WIDTH-1:0]          r_mem [MEM_SIZE];
    logic [NUM_READ*DATA_WIDTH-1:0] r_dout;
    logic [NUM_READ-1:0]            r_valid;
    logic [NUM_READ-1:0]            r_aerr;
    logic                           r_werr;

    logic                           w_run;
    logic                           w_wr_inrange;
    logic                           w_wr_ok;
    logic [IDX_W-1:0]               w_widx;
    logic [NUM_READ-1:0]            w_rd_inrange;
    logic [DATA_WIDTH-1:0]          w_rdata [NUM_READ];

    assign w_run        = (r_state == ST_RUN);
    assign w_wr_inrange = ({1'b0, iWriteAddress} < LP_LIMIT);
    assign w_wr_ok      = w_run && iWriteEnable && w_wr_inrange;
    assign w_widx       = iWriteAddress[IDX_W-1:0];

    for (genvar k = 0; k < NUM_READ; k++) begin : g_port
        logic [ADDR_WIDTH-1:0] w_raddr;
        assign w_raddr         = iReadAddress[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_rd_inrange[k] = ({1'b0, w_raddr} < LP_LIMIT);
`ifdef RAM_WRITE_FORWARD_EN
        assign w_rdata[k] = (w_wr_ok && (iWriteAddress == w_raddr)) ? iDataIn
                                                                    : r_mem[w_raddr[IDX_W-1:0]];
`else
        assign w_rdata[k] = r_mem[w_raddr[IDX_W-1:0]];
`endif
    end

    // The array itself has no reset; the sweep walking r_count is what zeroes it.
    always_ff @(posedge Clock) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_count] <= '0;
        end else if (w_wr_ok) begin
            r_mem[w_widx] <= iDataIn;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_CLEAR;
            r_count <= '0;
            r_dout  <= '0;
            r_valid <= '0;
            r_aerr  <= '0;
            r_werr  <= 1'b0;
        end else begin
            if (r_state == ST_CLEAR) begin
                if (r_count == LP_LAST) begin
                    r_state <= ST_RUN;
                    r_count <= '0;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end else if (iClear) begin
                r_state <= ST_CLEAR;
                r_count <= '0;
            end

            r_werr <= iWriteEnable && (!w_run || !w_wr_inrange);

            // An out-of-range address is flagged even while the sweep runs.
            for (int k = 0; k < NUM_READ; k++) begin
                r_valid[k] <= 1'b0;
                r_aerr[k]  <= 1'b0;
                if (iReadEnable[k]) begin
                    if (!w_rd_inrange[k]) begin
                        r_dout[k*DATA_WIDTH +: DATA_WIDTH] <= '0;
                        r_aerr[k]                          <= 1'b1;
                    end else if (!w_run) begin
                        r_dout[k*DATA_WIDTH +: DATA_WIDTH] <= '0;
                    end else begin
                        r_dout[k*DATA_WIDTH +: DATA_WIDTH] <= w_rdata[k];
                        r_valid[k]                         <= 1'b1;
                    end
                end
            end
        end
    end

    assign oDataOut    = r_dout;
    assign oDataValid  = r_valid;
    assign oAddrError  = r_aerr;
    assign oWriteError = r_werr;
    assign oBusy       = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_ram_multi_read_port.sv
// Scoreboard bench for ram_multi_read_port at its default sizes (16-bit data, 8 words, 2 read ports).
module tb_ram_multi_read_port;

    localparam logic [31:0] FWD =
`ifdef RAM_WRITE_FORWARD_EN
        32'h0000_AAAA;
`else
        32'h0000_0000;
`endif

    typedef struct {
        int          tag;
        logic [31:0] dout;
        logic [31:0] dmask;
        logic [31:0] vld;
        logic [31:0] aerr;
        logic [31:0] werr;
        logic [31:0] busy;
    } exp_t;

    logic        Clock;
    logic        Reset;
    logic        iClear;
    logic        iWriteEnable;
    logic [7:0]  iWriteAddress;
    logic [15:0] iDataIn;
    logic [1:0]  iReadEnable;
    logic [15:0] iReadAddress;
    logic [31:0] oDataOut;
    logic [1:0]  oDataValid;
    logic [1:0]  oAddrError;
    logic        oWriteError;
    logic        oBusy;

    int   cyc;
    int   n_chk;
    int   n_fail;
    exp_t q[$];
    exp_t m_e;

    ram_multi_read_port dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .iClear        (iClear),
        .iWriteEnable  (iWriteEnable),
        .iWriteAddress (iWriteAddress),
        .iDataIn       (iDataIn),
        .iReadEnable   (iReadEnable),
        .iReadAddress  (iReadAddress),
        .oDataOut      (oDataOut),
        .oDataValid    (oDataValid),
        .oAddrError    (oAddrError),
        .oWriteError   (oWriteError),
        .oBusy         (oBusy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    // Drives one cycle of stimulus (called at a falling edge) and queues the response due after the next rising edge.
    task automatic step(input logic [31:0] clr, input logic [31:0] we, input logic [31:0] wa,
                        input logic [31:0] wd, input logic [31:0] re, input logic [31:0] ra0,
                        input logic [31:0] ra1, input logic [31:0] ed, input logic [31:0] em,
                        input logic [31:0] ev, input logic [31:0] ea, input logic [31:0] ew,
                        input logic [31:0] eb);
        exp_t e;
        iClear        = clr[0];
        iWriteEnable  = we[0];
        iWriteAddress = wa[7:0];
        iDataIn       = wd[15:0];
        iReadEnable   = re[1:0];
        iReadAddress  = {ra1[7:0], ra0[7:0]};
        e.tag   = cyc + 1;
        e.dout  = ed;
        e.dmask = em;
        e.vld   = ev;
        e.aerr  = ea;
        e.werr  = ew;
        e.busy  = eb;
        q.push_back(e);
        @(negedge Clock);
    endtask

    task automatic idle(input logic [31:0] eb);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, eb);
    endtask

    task automatic read_all_zero();
        for (int a = 0; a < 8; a += 2)
            step(0, 0, 0, 0, 3, a, a + 1, 0, 3, 3, 0, 0, 0);
    endtask

    initial begin
        forever begin
            @(posedge Clock);
            #1;
            while (q.size() > 0 && q[0].tag <= cyc) begin
                m_e = q.pop_front();
                chk("sb_tag", 32'(cyc), 32'(m_e.tag));
                chk("busy", 32'(oBusy), m_e.busy);
                chk("werr", 32'(oWriteError), m_e.werr);
                chk("valid", 32'(oDataValid), m_e.vld);
                chk("aerr", 32'(oAddrError), m_e.aerr);
                if (m_e.dmask[0]) chk("dout0", 32'(oDataOut[15:0]), 32'(m_e.dout[15:0]));
                if (m_e.dmask[1]) chk("dout1", 32'(oDataOut[31:16]), 32'(m_e.dout[31:16]));
            end
        end
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        Reset = 1'b1;
        iClear = 1'b0;
        iWriteEnable = 1'b0;
        iWriteAddress = '0;
        iDataIn = '0;
        iReadEnable = '0;
        iReadAddress = '0;
        #2 Reset = 1'b0;
        #1;
        chk("rst_dout", oDataOut, 0);
        chk("rst_valid", 32'(oDataValid), 0);
        chk("rst_aerr", 32'(oAddrError), 0);
        chk("rst_werr", 32'(oWriteError), 0);
        chk("rst_busy", 32'(oBusy), 1);
        repeat (3) @(negedge Clock);

        // Release: busy for exactly 8 cycles, then every word reads zero.
        Reset = 1'b1;
        chk("rel_busy", 32'(oBusy), 1);
        repeat (7) idle(1);
        idle(0);
        read_all_zero();

        // Two writes then a dual-port read.
        step(0, 1, 3, 'hBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 5, 'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 3, 3, 5, 32'h1234_BEEF, 3, 3, 0, 0, 0);

        // Same-cycle write/read of address 2; port 1 holds its last data.
        step(0, 1, 2, 'hAAAA, 1, 2, 0, 32'h1234_0000 | FWD, 3, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 2, 0, 32'h1234_AAAA, 3, 1, 0, 0, 0);

        // Out-of-range read on port 1 and out-of-range write.
        step(0, 1, 8, 'hFFFF, 2, 0, 9, 32'h0000_AAAA, 3, 0, 2, 1, 0);
        step(0, 0, 0, 0, 3, 0, 7, 0, 3, 3, 0, 0, 0);

        // Clear sweep with a write on the iClear cycle, a read and a late write during the sweep.
        step(0, 0, 0, 0, 3, 3, 5, 32'h1234_BEEF, 3, 3, 0, 0, 0);
        step(1, 1, 1, 'h5555, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 3, 3, 5, 0, 3, 0, 0, 0, 1);
        repeat (6) idle(1);
        step(0, 1, 2, 'h7777, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        read_all_zero();

        // Reset in the middle of a sweep, at counter 4.
        step(0, 1, 6, 'h6666, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 6, 0, 32'h0000_6666, 3, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (4) idle(1);
        Reset = 1'b0;
        #1;
        chk("mid_dout", oDataOut, 0);
        chk("mid_valid", 32'(oDataValid), 0);
        chk("mid_busy", 32'(oBusy), 1);
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        chk("rel2_busy", 32'(oBusy), 1);
        repeat (7) idle(1);
        idle(0);
        read_all_zero();

        repeat (3) @(negedge Clock);
        chk("sb_empty", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_multi_read_port.md
Name: ram_multi_read_port

Overview:
- Parametrised register-file RAM with one write port and NUM_READ independent registered read ports.
- Successor to the two-read-port RAM:
  - generalised read-port count
  - per-port read enable with valid flag
  - range checking of addresses
  - hardware clear sweep after reset or on request
- Feeds operand reads for the datapath; the write port is driven by the writeback stage.

Parameters:
- DATA_WIDTH, 16, bits per word
- ADDR_WIDTH, 8, address bits per port
- MEM_SIZE, 8, number of words; legal addresses 0..MEM_SIZE-1; MEM_SIZE <= 2^ADDR_WIDTH
- NUM_READ, 2, number of read ports; range 1..8

Ports:
- Clock  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-low reset
- iClear  input  1  single-cycle pulse requesting a zero sweep of the whole memory
- iWriteEnable  input  1  write strobe
- iWriteAddress  input  ADDR_WIDTH  write address
- iDataIn  input  DATA_WIDTH  write data
- iReadEnable  input  NUM_READ  per-port read request; bit k belongs to port k
- iReadAddress  input  NUM_READ*ADDR_WIDTH  packed read addresses; port k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- oDataOut  output  NUM_READ*DATA_WIDTH  packed registered read data; port k uses bits [k*DATA_WIDTH +: DATA_WIDTH]
- oDataValid  output  NUM_READ  per-port valid; meaningful one cycle after the request
- oAddrError  output  NUM_READ  per-port out-of-range flag, registered
- oWriteError  output  1  registered; set for one cycle on an out-of-range or blocked write
- oBusy  output  1  high while the clear sweep runs

Behaviour:
- Reset (Reset=0, asynchronous):
  - oDataOut=0, oDataValid=0, oAddrError=0, oWriteError=0
  - FSM=CLEAR, sweep counter=0, oBusy=1
  - Memory array is not reset directly; the sweep zeroes it.
- FSM has two states: CLEAR and RUN.
- CLEAR:
  - Each cycle writes 0 to Ram[counter], then counter increments.
  - When counter==MEM_SIZE-1 is written, next state is RUN and counter returns to 0.
  - Sweep takes exactly MEM_SIZE cycles.
- RUN:
  - iClear=1 moves to CLEAR on the next edge.
  - A write in the same cycle as iClear is still performed; the sweep then overwrites it.
- Writes (RUN only):
  - If iWriteEnable and iWriteAddress<MEM_SIZE: Ram[iWriteAddress]<=iDataIn.
  - Out-of-range write: memory unchanged, oWriteError=1 next cycle.
  - Write during CLEAR: ignored, oWriteError=1 next cycle.
- Reads, port k, evaluated independently each cycle with latency 1:
  - If iReadEnable[k] and RUN and address<MEM_SIZE: oDataOut[k]<=Ram[addr], oDataValid[k]<=1, oAddrError[k]<=0.
  - If iReadEnable[k] and address>=MEM_SIZE: oDataOut[k]<=0, oDataValid[k]<=0, oAddrError[k]<=1.
  - If iReadEnable[k] during CLEAR: oDataOut[k]<=0, oDataValid[k]<=0, oAddrError[k]<=0.
  - If iReadEnable[k]=0: oDataOut[k] holds its last value; oDataValid[k]<=0, oAddrError[k]<=0.
- Several ports reading the same address in one cycle all receive identical data.
- Read and write to the same address in the same cycle: result depends on the optional feature below.
- Reset asserted mid-sweep or mid-operation: immediate return to reset values and a full sweep restart.
- oBusy is the registered state: 1 in CLEAR, 0 in RUN.

Optional Feature:
- Macro: RAM_WRITE_FORWARD_EN.
- Defined: a read in RUN whose address equals an in-range iWriteAddress with iWriteEnable=1 in the same cycle returns iDataIn (write-first). Applies independently to every port.
- Undefined: such a read returns the old Ram contents (read-first). The new value is visible from the following cycle onward.

Test Plan:
- Reset release, MEM_SIZE=8 -> oBusy=1 for exactly 8 cycles then 0; reading addresses 0..7 returns 0x0000 with oDataValid=1.
- Write 0xBEEF to address 3, then 0x1234 to address 5, then ports 0/1 read 3/5 in one cycle -> next cycle oDataOut port0=0xBEEF, port1=0x1234, oDataValid=2'b11.
- Write 0xAAAA to address 2 and port 0 reads address 2 in the same cycle -> 0xAAAA with RAM_WRITE_FORWARD_EN, previous value (0x0000 after sweep) without it.
- Port 1 reads address 9 and a write targets address 8 (MEM_SIZE=8) -> oAddrError=2'b10, oDataValid[1]=0, oDataOut port1=0, oWriteError=1, memory unchanged.
- After populating data, pulse iClear, then write during the sweep and read during the sweep -> oBusy high 8 cycles, oWriteError=1, reads have oDataValid=0; afterwards all addresses read 0x0000.
- Drop Reset low during the sweep at counter=4 -> outputs go to zero immediately; after release oBusy stays high a full 8 cycles.
